// File: rtl/ship_pkg.sv
// ship_pkg: shared constants and types for the ship tracker.
//   SHIP_LEN  - length of each ship slot (slots 5..7 only used when NUM_SHIPS > 5)
//   MAX_LEN   - widest hit bitmap
//   state_e   - tracker FSM states
//   slot_t    - one placement slot inside the 32-bit ship_data word
package ship_pkg;

  localparam int MAX_SHIPS = 8;
  localparam int IDX_W     = 3;
  localparam int MAX_LEN   = 5;
  localparam int OFF_W     = $clog2(MAX_LEN);

  localparam int SHIP_LEN [MAX_SHIPS] = '{5, 4, 3, 3, 2, 2, 2, 2};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // Slot A occupies [31:21] (pos[31:25], vert[24], idx[23:21]),
  // slot B occupies [20:10] (pos[20:14], vert[13], idx[12:10]).
  typedef struct packed {
    logic [6:0]       pos;
    logic             vert;
    logic [IDX_W-1:0] idx;
  } slot_t;

  localparam int SLOT_W         = $bits(slot_t);
  localparam int SLOT_A_IDX_LSB = 21;
  localparam int SLOT_A_VERT    = 24;
  localparam int SLOT_A_POS_LSB = 25;
  localparam int SLOT_B_IDX_LSB = 10;
  localparam int SLOT_B_VERT    = 13;
  localparam int SLOT_B_POS_LSB = 14;

  // Bitmap value of a fully hit ship.
  function automatic logic [MAX_LEN-1:0] full_mask(input logic [IDX_W-1:0] idx);
    return MAX_LEN'((1 << SHIP_LEN[idx]) - 1);
  endfunction

endpackage

// File: rtl/pos_decode.sv
// pos_decode: splits a linear cell index into row and column.
//   pos_i  - cell index (row*BOARD_DIM + col)
//   row_o  - pos_i / BOARD_DIM
//   col_o  - pos_i % BOARD_DIM
// The divisor is a parameter, so synthesis reduces this to constant logic.
module pos_decode #(
  parameter int BOARD_DIM = 10,
  parameter int POS_W     = 7
) (
  input  logic [POS_W-1:0] pos_i,
  output logic [POS_W-1:0] row_o,
  output logic [POS_W-1:0] col_o
);

  localparam logic [POS_W-1:0] DIM = POS_W'(BOARD_DIM);

  assign row_o = pos_i / DIM;
  assign col_o = pos_i % DIM;

endmodule

// File: rtl/ship_tracker.sv
// ship_tracker: battleship board tracker.
//   clk, rst_n          - clock, async active-low reset
//   ship_data, enable   - two placement slots, loaded when enable is high in IDLE
//   clear               - synchronous new-game clear (highest priority)
//   shot_valid/ready    - shot request handshake, shot_pos is the target cell
//   result_*            - one-cycle shot result (hit, sunk, repeat, ship index)
//   all_sunk            - every loaded ship fully hit
// A shot spends one cycle registering the decoded shot coordinates, then
// checks one ship per cycle in index order; the first matching ship wins.
module ship_tracker
  import ship_pkg::*;
#(
  parameter int NUM_SHIPS = 5,
  parameter int BOARD_DIM = 10,
  parameter int POS_W     = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      ship_data,
  input  logic             enable,
  input  logic             clear,
  input  logic             shot_valid,
  input  logic [POS_W-1:0] shot_pos,
  output logic             shot_ready,
  output logic             result_valid,
  output logic             result_hit,
  output logic             result_sunk,
  output logic             result_repeat,
  output logic [IDX_W-1:0] result_ship,
  output logic             all_sunk
);

  // Ship storage
  logic [POS_W-1:0]   pos_q [NUM_SHIPS];
  logic [POS_W-1:0]   pos_d [NUM_SHIPS];
  logic [MAX_LEN-1:0] hit_q [NUM_SHIPS];
  logic [MAX_LEN-1:0] hit_d [NUM_SHIPS];
  logic [NUM_SHIPS-1:0] vert_q, vert_d, loaded_q, loaded_d;
  logic all_sunk_q, all_sunk_d;

  // FSM / shot context
  state_e           state_q;
  logic             prime_q;
  logic [IDX_W-1:0] scan_idx_q;
  logic [POS_W-1:0] shot_pos_q, shot_row_q, shot_col_q;
  logic             shot_oob_q;

  logic             result_valid_q, result_hit_q, result_sunk_q, result_repeat_q;
  logic [IDX_W-1:0] result_ship_q;

  slot_t slot_a, slot_b;
  assign slot_a = slot_t'(ship_data[SLOT_A_IDX_LSB +: SLOT_W]);
  assign slot_b = slot_t'(ship_data[SLOT_B_IDX_LSB +: SLOT_W]);

  logic [POS_W-1:0] shot_row_w, shot_col_w, ship_row_w, ship_col_w;

  pos_decode #(.BOARD_DIM(BOARD_DIM), .POS_W(POS_W)) u_shot_dec (
    .pos_i (shot_pos_q),
    .row_o (shot_row_w),
    .col_o (shot_col_w)
  );

  pos_decode #(.BOARD_DIM(BOARD_DIM), .POS_W(POS_W)) u_ship_dec (
    .pos_i (pos_q[scan_idx_q]),
    .row_o (ship_row_w),
    .col_o (ship_col_w)
  );

  // Compare the ship under scan against the registered shot
  logic [POS_W-1:0]   len_w, dcol, drow, off_w;
  logic [MAX_LEN-1:0] hit_mask, hit_new;
  logic               h_ok, v_ok, scan_hit, hit_repeat, hit_sunk;

  always_comb begin
    len_w = POS_W'(SHIP_LEN[scan_idx_q]);
    dcol  = shot_col_q - ship_col_w;
    drow  = shot_row_q - ship_row_w;
    // Same-row / same-col requirement keeps footprints from wrapping past the edge.
    h_ok  = !vert_q[scan_idx_q] && (ship_row_w == shot_row_q) &&
            (shot_col_q >= ship_col_w) && (dcol < len_w);
    v_ok  =  vert_q[scan_idx_q] && (ship_col_w == shot_col_q) &&
            (shot_row_q >= ship_row_w) && (drow < len_w);
    off_w      = vert_q[scan_idx_q] ? drow : dcol;
    hit_mask   = MAX_LEN'(1) << off_w[OFF_W-1:0];
    hit_new    = hit_q[scan_idx_q] | hit_mask;
    hit_repeat = |(hit_q[scan_idx_q] & hit_mask);
    hit_sunk   = !hit_repeat && (hit_new == full_mask(scan_idx_q));
    scan_hit   = (state_q == S_SCAN) && !prime_q && !shot_oob_q &&
                 loaded_q[scan_idx_q] && (h_ok || v_ok);
  end

  // Ship storage next state: clear > load (IDLE only) > hit update
  always_comb begin
    pos_d    = pos_q;
    hit_d    = hit_q;
    vert_d   = vert_q;
    loaded_d = loaded_q;
    if (clear) begin
      for (int i = 0; i < NUM_SHIPS; i++) begin
        pos_d[i] = '0;
        hit_d[i] = '0;
      end
      vert_d   = '0;
      loaded_d = '0;
    end else if (state_q == S_IDLE && enable) begin
      // Slot B is applied after slot A so it wins on a shared index.
      for (int i = 0; i < NUM_SHIPS; i++) begin
        if (slot_a.idx == IDX_W'(i)) begin
          pos_d[i]    = POS_W'(slot_a.pos);
          vert_d[i]   = slot_a.vert;
          loaded_d[i] = 1'b1;
          hit_d[i]    = '0;
        end
        if (slot_b.idx == IDX_W'(i)) begin
          pos_d[i]    = POS_W'(slot_b.pos);
          vert_d[i]   = slot_b.vert;
          loaded_d[i] = 1'b1;
          hit_d[i]    = '0;
        end
      end
    end else if (scan_hit) begin
      hit_d[scan_idx_q] = hit_new;
    end

    all_sunk_d = |loaded_d;
    for (int i = 0; i < NUM_SHIPS; i++)
      if (loaded_d[i] && (hit_d[i] != full_mask(IDX_W'(i)))) all_sunk_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SHIPS; i++) begin
        pos_q[i] <= '0;
        hit_q[i] <= '0;
      end
      vert_q          <= '0;
      loaded_q        <= '0;
      all_sunk_q      <= 1'b0;
      state_q         <= S_IDLE;
      prime_q         <= 1'b0;
      scan_idx_q      <= '0;
      shot_pos_q      <= '0;
      shot_row_q      <= '0;
      shot_col_q      <= '0;
      shot_oob_q      <= 1'b0;
      result_valid_q  <= 1'b0;
      result_hit_q    <= 1'b0;
      result_sunk_q   <= 1'b0;
      result_repeat_q <= 1'b0;
      result_ship_q   <= '0;
    end else begin
      pos_q      <= pos_d;
      hit_q      <= hit_d;
      vert_q     <= vert_d;
      loaded_q   <= loaded_d;
      all_sunk_q <= all_sunk_d;

      // Results are only nonzero during their single valid cycle.
      result_valid_q  <= 1'b0;
      result_hit_q    <= 1'b0;
      result_sunk_q   <= 1'b0;
      result_repeat_q <= 1'b0;
      result_ship_q   <= '0;

      if (clear) begin
        state_q    <= S_IDLE;
        prime_q    <= 1'b0;
        scan_idx_q <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (shot_valid) begin
              shot_pos_q <= shot_pos;
              state_q    <= S_SCAN;
              prime_q    <= 1'b1;
              scan_idx_q <= '0;
            end
          end
          S_SCAN: begin
            if (prime_q) begin
              // Register decoded shot so the divider is off the compare path.
              prime_q    <= 1'b0;
              shot_row_q <= shot_row_w;
              shot_col_q <= shot_col_w;
              shot_oob_q <= (shot_pos_q >= POS_W'(BOARD_DIM * BOARD_DIM));
            end else if (scan_hit) begin
              state_q         <= S_RESP;
              result_valid_q  <= 1'b1;
              result_hit_q    <= 1'b1;
              result_sunk_q   <= hit_sunk;
              result_repeat_q <= hit_repeat;
              result_ship_q   <= scan_idx_q;
            end else if (scan_idx_q == IDX_W'(NUM_SHIPS - 1)) begin
              state_q        <= S_RESP;
              result_valid_q <= 1'b1;
            end else begin
              scan_idx_q <= scan_idx_q + 1'b1;
            end
          end
          S_RESP:  state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign shot_ready    = (state_q == S_IDLE);
  assign result_valid  = result_valid_q;
  assign result_hit    = result_hit_q;
  assign result_sunk   = result_sunk_q;
  assign result_repeat = result_repeat_q;
  assign result_ship   = result_ship_q;
  assign all_sunk      = all_sunk_q;

  logic unused_bits;
  assign unused_bits = ^{ship_data[SLOT_B_IDX_LSB-1:0], off_w[POS_W-1:OFF_W]};

endmodule

// File: tb/tb_ship_tracker.sv
module tb_ship_tracker;

  localparam int N   = 5;
  localparam int DIM = 10;
  localparam int LEN [5] = '{5, 4, 3, 3, 2};

  logic       clk = 1'b0, rst_n = 1'b0;
  logic [31:0] ship_data = '0;
  logic       enable = 1'b0, clear = 1'b0, shot_valid = 1'b0;
  logic [6:0] shot_pos = '0;
  logic       shot_ready, result_valid, result_hit, result_sunk, result_repeat, all_sunk;
  logic [2:0] result_ship;

  ship_tracker dut (
    .clk(clk), .rst_n(rst_n), .ship_data(ship_data), .enable(enable), .clear(clear),
    .shot_valid(shot_valid), .shot_pos(shot_pos), .shot_ready(shot_ready),
    .result_valid(result_valid), .result_hit(result_hit), .result_sunk(result_sunk),
    .result_repeat(result_repeat), .result_ship(result_ship), .all_sunk(all_sunk)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;

  // Reference model: ship footprints as explicit cell lists
  int m_pos [N];
  bit m_vert [N];
  bit m_loaded [N];
  bit m_hit [N][5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] word(int ap, bit av, int ai, int bp, bit bv, int bi);
    return {7'(ap), av, 3'(ai), 7'(bp), bv, 3'(bi), 10'd0};
  endfunction

  // Cell covered by offset o of ship i, or -1 when it falls off the board.
  function automatic int m_cell(int i, int o);
    int r = m_pos[i] / DIM;
    int c = m_pos[i] % DIM;
    if (m_vert[i]) r += o; else c += o;
    if (r >= DIM || c >= DIM) return -1;
    return r * DIM + c;
  endfunction

  function automatic bit m_all_sunk();
    bit any = 0;
    for (int i = 0; i < N; i++) begin
      if (!m_loaded[i]) continue;
      any = 1;
      for (int o = 0; o < LEN[i]; o++) if (!m_hit[i][o]) return 0;
    end
    return any;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < N; i++) begin
      m_pos[i] = 0; m_vert[i] = 0; m_loaded[i] = 0;
      for (int o = 0; o < 5; o++) m_hit[i][o] = 0;
    end
  endtask

  task automatic m_place(int p, bit v, int idx);
    if (idx >= N) return;
    m_pos[idx] = p; m_vert[idx] = v; m_loaded[idx] = 1;
    for (int o = 0; o < 5; o++) m_hit[idx][o] = 0;
  endtask

  task automatic m_load(input logic [31:0] w);
    m_place(int'(w[31:25]), w[24], int'(w[23:21]));
    m_place(int'(w[20:14]), w[13], int'(w[12:10]));
  endtask

  task automatic m_shot(input int p, output bit hit, output int ship, output bit sunk, output bit rep);
    hit = 0; ship = 0; sunk = 0; rep = 0;
    if (p >= DIM * DIM) return;
    for (int i = 0; i < N; i++) begin
      if (!m_loaded[i]) continue;
      for (int o = 0; o < LEN[i]; o++) begin
        if (m_cell(i, o) == p) begin
          hit = 1; ship = i; rep = m_hit[i][o];
          m_hit[i][o] = 1;
          sunk = !rep;
          for (int q = 0; q < LEN[i]; q++) if (!m_hit[i][q]) sunk = 0;
          return;
        end
      end
    end
  endtask

  task automatic do_clear();
    clear = 1; tick(); clear = 0;
    m_clear();
    check("all_sunk_after_clear", all_sunk, 0);
  endtask

  task automatic do_load(input logic [31:0] w);
    ship_data = w; enable = 1; tick(); enable = 0;
    m_load(w);
    check("all_sunk_after_load", all_sunk, m_all_sunk());
  endtask

  task automatic start_shot(input logic [6:0] p);
    check("ready_before_shot", shot_ready, 1);
    shot_pos = p; shot_valid = 1; tick(); shot_valid = 0;
    check("ready_busy", shot_ready, 0);
  endtask

  task automatic finish_shot(input int lat0, input bit eh, input int es, input bit esk,
                             input bit erp, input bit eas);
    int lat = lat0;
    bit got = 0;
    while (!got && lat < 20) begin
      tick(); lat++; got = result_valid;
    end
    check("result_seen", got, 1);
    if (got) begin
      check("latency", lat, eh ? es + 2 : N + 1);
      check("hit", result_hit, eh);
      check("ship", result_ship, eh ? es : 0);
      check("sunk", result_sunk, esk);
      check("repeat", result_repeat, erp);
      check("all_sunk", all_sunk, eas);
    end
    tick();
    check("valid_one_cycle", result_valid, 0);
    check("ready_after_resp", shot_ready, 1);
  endtask

  task automatic model_shot(input logic [6:0] p);
    bit h, sk, rp; int s;
    m_shot(int'(p), h, s, sk, rp);
    start_shot(p);
    finish_shot(0, h, s, sk, rp, m_all_sunk());
  endtask

  task automatic count_quiet(input string name, input int cycles);
    int seen = 0;
    for (int c = 0; c < cycles; c++) begin
      tick();
      if (result_valid) seen++;
    end
    check(name, seen, 0);
  endtask

  typedef struct {
    logic [6:0] pos;
    bit hit; int ship; bit sunk; bit rep;
  } vec_t;

  vec_t tbl [13];

  initial begin
    bit h, sk, rp; int s;

    tbl[0]  = '{7'd14,  1, 0, 0, 0};
    tbl[1]  = '{7'd65,  1, 1, 0, 0};
    tbl[2]  = '{7'd20,  0, 0, 0, 0};  // right of ship 4 on next row: no wrap
    tbl[3]  = '{7'd18,  1, 4, 0, 0};
    tbl[4]  = '{7'd19,  1, 4, 1, 0};
    tbl[5]  = '{7'd18,  1, 4, 0, 1};
    tbl[6]  = '{7'd100, 0, 0, 0, 0};
    tbl[7]  = '{7'd14,  1, 0, 0, 1};
    tbl[8]  = '{7'd127, 0, 0, 0, 0};
    tbl[9]  = '{7'd16,  1, 0, 0, 0};  // last cell of ship 0
    tbl[10] = '{7'd17,  0, 0, 0, 0};  // one past ship 0
    tbl[11] = '{7'd35,  0, 0, 0, 0};  // just above vertical ship 1
    tbl[12] = '{7'd85,  0, 0, 0, 0};  // just below vertical ship 1

    // Reset state
    m_clear();
    tick(); tick();
    check("rst_result_valid", result_valid, 0);
    check("rst_result_hit", result_hit, 0);
    check("rst_result_ship", result_ship, 0);
    check("rst_all_sunk", all_sunk, 0);
    rst_n = 1; tick();
    check("rst_shot_ready", shot_ready, 1);

    // Directed table
    do_load(word(12, 0, 0, 45, 1, 1));
    do_load(word(18, 0, 4, 0, 0, 7));
    for (int t = 0; t < 13; t++) begin
      m_shot(int'(tbl[t].pos), h, s, sk, rp);
      start_shot(tbl[t].pos);
      finish_shot(0, tbl[t].hit, tbl[t].ship, tbl[t].sunk, tbl[t].rep, 0);
    end

    // Both slots on idx 2: slot B placement wins; enable during scan ignored
    do_clear();
    do_load(word(30, 0, 2, 50, 0, 2));
    m_shot(50, h, s, sk, rp);
    start_shot(7'd50); finish_shot(0, 1, 2, 0, 0, 0);
    m_shot(30, h, s, sk, rp);
    start_shot(7'd30); finish_shot(0, 0, 0, 0, 0, 0);
    m_shot(51, h, s, sk, rp);
    start_shot(7'd51);
    ship_data = word(0, 0, 3, 0, 0, 7); enable = 1; tick(); enable = 0;
    finish_shot(1, 1, 2, 0, 0, 0);
    m_shot(0, h, s, sk, rp);
    start_shot(7'd0); finish_shot(0, 0, 0, 0, 0, 0);

    // Clear wins over enable and shot acceptance in the same cycle
    ship_data = word(60, 0, 0, 0, 0, 7);
    clear = 1; enable = 1; shot_valid = 1; shot_pos = 7'd50;
    tick();
    clear = 0; enable = 0; shot_valid = 0;
    m_clear();
    check("clear_prio_ready", shot_ready, 1);
    count_quiet("clear_prio_no_result", 8);
    model_shot(7'd50);
    model_shot(7'd60);

    // Every ship loaded, every cell shot
    do_clear();
    do_load(word(0, 0, 0, 10, 0, 1));
    do_load(word(20, 0, 2, 30, 0, 3));
    do_load(word(40, 0, 4, 0, 0, 7));
    for (int p = 0; p < DIM * DIM; p++) model_shot(7'(p));
    check("all_sunk_final", all_sunk, 1);
    do_clear();
    check("all_sunk_cleared", all_sunk, 0);

    // Reset in the middle of a scan discards the shot
    do_load(word(70, 0, 4, 0, 0, 7));
    start_shot(7'd71);
    tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    m_clear();
    count_quiet("reset_no_result", 10);
    check("reset_ready", shot_ready, 1);
    check("reset_all_sunk", all_sunk, 0);
    model_shot(7'd100);
    model_shot(7'd71);

    // Randomized against the reference model
    for (int it = 0; it < 80; it++) begin
      int r = $urandom_range(0, 99);
      if (r < 5) begin
        do_clear();
      end else if (r < 30) begin
        int ap = ($urandom_range(0, 9) == 0) ? $urandom_range(100, 127) : $urandom_range(0, 99);
        int bp = $urandom_range(0, 99);
        do_load(word(ap, 1'($urandom_range(0, 1)), $urandom_range(0, 7),
                     bp, 1'($urandom_range(0, 1)), $urandom_range(0, 7)));
      end else begin
        int i = $urandom_range(0, N - 1);
        int p = -1;
        if (m_loaded[i] && $urandom_range(0, 1) == 1) p = m_cell(i, $urandom_range(0, LEN[i] - 1));
        if (p < 0) p = $urandom_range(0, 109);
        model_shot(7'(p));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
